// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ_IF,
      REQ_LSU,
      RSP_IF,
      RSP_LSU
   } arb_state_t;

   typedef enum logic {
      ARB_IF,
      ARB_LSU
   } arb_src_t;

   // LSU wins unless IF is competing and the LSU has used up its streak.
   function automatic arb_src_t arb_pick(input logic if_req_i,
                                         input logic lsu_req_i,
                                         input logic streak_full_i);
      if (lsu_req_i && !(if_req_i && streak_full_i)) begin
         return ARB_LSU;
      end
      return ARB_IF;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and bus signals of the arbiter; slave is the arbiter's view,
// master is the view of whatever drives the requesters and the bus.
interface mem_port_arbiter_if #(
   parameter int XLEN = 32
);
   logic              i_if_req;
   logic [XLEN-1:0]   i_if_addr;
   logic              i_if_flush;
   logic              o_if_rvalid;
   logic [XLEN-1:0]   o_if_rdata;
   logic              o_stall_if;

   logic              i_lsu_req;
   logic              i_lsu_we;
   logic [XLEN/8-1:0] i_lsu_be;
   logic [XLEN-1:0]   i_lsu_addr;
   logic [XLEN-1:0]   i_lsu_wdata;
   logic              o_lsu_rvalid;
   logic [XLEN-1:0]   o_lsu_rdata;
   logic              o_stall_mem;

   logic              o_bus_req;
   logic              o_bus_we;
   logic [XLEN/8-1:0] o_bus_be;
   logic [XLEN-1:0]   o_bus_addr;
   logic [XLEN-1:0]   o_bus_wdata;
   logic              i_bus_gnt;
   logic              i_bus_rvalid;
   logic [XLEN-1:0]   i_bus_rdata;

   modport slave (
      input  i_if_req, i_if_addr, i_if_flush,
      output o_if_rvalid, o_if_rdata, o_stall_if,
      input  i_lsu_req, i_lsu_we, i_lsu_be, i_lsu_addr, i_lsu_wdata,
      output o_lsu_rvalid, o_lsu_rdata, o_stall_mem,
      output o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
      input  i_bus_gnt, i_bus_rvalid, i_bus_rdata
   );

   modport master (
      output i_if_req, i_if_addr, i_if_flush,
      input  o_if_rvalid, o_if_rdata, o_stall_if,
      output i_lsu_req, i_lsu_we, i_lsu_be, i_lsu_addr, i_lsu_wdata,
      input  o_lsu_rvalid, o_lsu_rdata, o_stall_mem,
      input  o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata,
      output i_bus_gnt, i_bus_rvalid, i_bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the LSU, one
// transaction in flight, LSU priority with a starvation guard for IF.
//
// state   | meaning
// IDLE    | arbitrate between IF and LSU requests
// REQ_IF  | fetch request on the bus, waiting for gnt
// REQ_LSU | load/store request on the bus, waiting for gnt
// RSP_IF  | fetch granted, waiting for rvalid (dropped if killed)
// RSP_LSU | load/store granted, waiting for rvalid
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int MAX_LSU_STREAK = 4
) (
   input logic              i_clk,
   input logic              i_rst,
   mem_port_arbiter_if.slave mp
);

   localparam int                  STREAK_W   = $clog2(MAX_LSU_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

   arb_state_t          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                kill_q, kill_d;
   logic [XLEN-1:0]     addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [XLEN/8-1:0]   be_q, be_d;
   logic                we_q, we_d;
   logic                if_win, lsu_win;
   logic                if_cand;
   arb_src_t            winner;

   // A flush in IDLE means the presented fetch address is already stale.
   assign if_cand = mp.i_if_req & ~mp.i_if_flush;
   assign winner  = arb_pick(if_cand, mp.i_lsu_req, streak_q == STREAK_MAX);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         streak_q <= '0;
         kill_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         kill_q   <= kill_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         we_q     <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      kill_d  = kill_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      we_d    = we_q;
      if_win  = 1'b0;
      lsu_win = 1'b0;

      case (state_q)
         IDLE: begin
            if (mp.i_lsu_req || if_cand) begin
               if (winner == ARB_LSU) begin
                  lsu_win = 1'b1;
                  state_d = REQ_LSU;
                  addr_d  = mp.i_lsu_addr;
                  wdata_d = mp.i_lsu_wdata;
                  be_d    = mp.i_lsu_be;
                  we_d    = mp.i_lsu_we;
               end else begin
                  if_win  = 1'b1;
                  state_d = REQ_IF;
                  addr_d  = mp.i_if_addr;
                  wdata_d = '0;
                  be_d    = '1;
                  we_d    = 1'b0;
               end
            end
         end
         REQ_IF: begin
            if (mp.i_if_flush) kill_d = 1'b1;
            if (mp.i_bus_gnt) state_d = RSP_IF;
         end
         REQ_LSU: begin
            if (mp.i_bus_gnt) state_d = RSP_LSU;
         end
         RSP_IF: begin
            if (mp.i_if_flush) kill_d = 1'b1;
            if (mp.i_bus_rvalid) begin
               state_d = IDLE;
               kill_d  = 1'b0;
            end
         end
         RSP_LSU: begin
            if (mp.i_bus_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      streak_d = streak_q;
      if (!mp.i_if_req || if_win) begin
         streak_d = '0;
      end else if (lsu_win && streak_q != STREAK_MAX) begin
         streak_d = streak_q + 1'b1;
      end
   end

   assign mp.o_bus_req   = (state_q == REQ_IF) || (state_q == REQ_LSU);
   assign mp.o_bus_we    = we_q;
   assign mp.o_bus_be    = be_q;
   assign mp.o_bus_addr  = addr_q;
   assign mp.o_bus_wdata = wdata_q;

   assign mp.o_if_rvalid  = (state_q == RSP_IF) & mp.i_bus_rvalid & ~kill_q;
   assign mp.o_lsu_rvalid = (state_q == RSP_LSU) & mp.i_bus_rvalid;
   assign mp.o_if_rdata   = mp.i_bus_rdata;
   assign mp.o_lsu_rdata  = mp.i_bus_rdata;

   // Requests are still held during reset; keep the stalls quiet until release.
   assign mp.o_stall_if  = mp.i_if_req  & ~mp.o_if_rvalid  & ~i_rst;
   assign mp.o_stall_mem = mp.i_lsu_req & ~mp.o_lsu_rvalid & ~i_rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural bus with programmable gnt/rvalid
// delays, per-port response scoreboards, vector table and corner sequences.
module tb_mem_port_arbiter;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;

   mem_port_arbiter_if #(.XLEN(32)) mp();

   mem_port_arbiter #(.XLEN(32), .MAX_LSU_STREAK(4)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .mp    (mp)
   );

   always #5 i_clk = ~i_clk;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge i_clk) cyc++;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          cyc;
   } bus_txn_t;

   typedef struct {
      logic        is_lsu;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gd;
      int          rd;
      logic        wig;
      logic        exp_we;
      logic [3:0]  exp_be;
      int          exp_stall;
   } vec_t;

   bus_txn_t    bus_log[$];
   logic [31:0] if_exp[$];
   logic [31:0] lsu_exp[$];
   vec_t        vt[7];
   logic [31:0] exp_order[12];

   int          gnt_delay = 0;
   int          rsp_delay = 0;
   int          bcnt      = 0;
   logic        pend      = 1'b0;
   logic [31:0] lat_addr  = '0;
   logic        lat_we    = 1'b0;

   function automatic logic [31:0] rsp_of(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input string msg);
      n_assert++;
      n_fail++;
      $display("FAIL %s: %s", name, msg);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   // Bus model: decides gnt/rvalid for the cycle just after each clock edge.
   always begin
      @(posedge i_clk);
      #1;
      if (i_rst) begin
         mp.i_bus_gnt    = 1'b0;
         mp.i_bus_rvalid = 1'b0;
         mp.i_bus_rdata  = '0;
         pend            = 1'b0;
         bcnt            = 0;
      end else if (mp.i_bus_rvalid) begin
         mp.i_bus_rvalid = 1'b0;
         pend            = 1'b0;
         bcnt            = 0;
      end else begin
         if (mp.i_bus_gnt) begin
            mp.i_bus_gnt = 1'b0;
            pend         = 1'b1;
            bcnt         = 0;
         end
         if (pend) begin
            if (bcnt >= rsp_delay) begin
               mp.i_bus_rvalid = 1'b1;
               mp.i_bus_rdata  = lat_we ? 32'h0 : rsp_of(lat_addr);
            end else begin
               bcnt++;
            end
         end else if (mp.o_bus_req) begin
            if (bcnt >= gnt_delay) begin
               mp.i_bus_gnt = 1'b1;
               lat_addr     = mp.o_bus_addr;
               lat_we       = mp.o_bus_we;
               bus_log.push_back('{mp.o_bus_addr, mp.o_bus_we, mp.o_bus_be, mp.o_bus_wdata, cyc});
               bcnt         = 0;
            end else begin
               bcnt++;
            end
         end
      end
   end

   // Response monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge i_clk) begin
      if (!i_rst) begin
         if (mp.o_if_rvalid) begin
            if (if_exp.size() == 0) fail_now("if_rvalid_unexpected", $sformatf("got rdata %h, required no response", mp.o_if_rdata));
            else chk("if_rdata", mp.o_if_rdata, if_exp.pop_front());
         end
         if (mp.o_lsu_rvalid) begin
            if (lsu_exp.size() == 0) fail_now("lsu_rvalid_unexpected", $sformatf("got rdata %h, required no response", mp.o_lsu_rdata));
            else chk("lsu_rdata", mp.o_lsu_rdata, lsu_exp.pop_front());
         end
      end
   end

   task automatic if_fetch(input logic [31:0] a, output int stalls);
      int   n;
      logic done;
      if_exp.push_back(rsp_of(a));
      mp.i_if_req  = 1'b1;
      mp.i_if_addr = a;
      stalls = 0;
      n      = 0;
      done   = 1'b0;
      while (!done && n < 300) begin
         @(negedge i_clk);
         if (mp.o_stall_if) stalls++;
         done = mp.o_if_rvalid;
         @(posedge i_clk);
         #1;
         n++;
      end
      mp.i_if_req = 1'b0;
      if (!done) fail_now("if_fetch_timeout", $sformatf("no o_if_rvalid for addr %h within 300 cycles", a));
   endtask

   task automatic lsu_op(input logic we, input logic [3:0] be, input logic [31:0] a,
                         input logic [31:0] wd, input logic wig, output int stalls);
      int   n;
      logic done;
      lsu_exp.push_back(we ? 32'h0 : rsp_of(a));
      mp.i_lsu_req   = 1'b1;
      mp.i_lsu_we    = we;
      mp.i_lsu_be    = be;
      mp.i_lsu_addr  = a;
      mp.i_lsu_wdata = wd;
      stalls = 0;
      n      = 0;
      done   = 1'b0;
      while (!done && n < 300) begin
         @(negedge i_clk);
         if (mp.o_stall_mem) stalls++;
         done = mp.o_lsu_rvalid;
         if (wig && mp.o_bus_req) chk("held_bus_addr", mp.o_bus_addr, a);
         @(posedge i_clk);
         #1;
         if (wig) begin
            mp.i_lsu_addr  = $urandom;
            mp.i_lsu_wdata = $urandom;
         end
         n++;
      end
      mp.i_lsu_req = 1'b0;
      if (!done) fail_now("lsu_op_timeout", $sformatf("no o_lsu_rvalid for addr %h within 300 cycles", a));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s1, s2;

      vt[0] = '{1'b0, 1'b0, 4'h0, 32'h100, 32'h0,         0, 0, 1'b0, 1'b0, 4'hF, 2};
      vt[1] = '{1'b1, 1'b0, 4'hF, 32'h40,  32'h0,         0, 0, 1'b0, 1'b0, 4'hF, 2};
      vt[2] = '{1'b1, 1'b1, 4'h3, 32'h200, 32'h1234_5678, 2, 1, 1'b0, 1'b1, 4'h3, 5};
      vt[3] = '{1'b0, 1'b0, 4'h0, 32'h104, 32'h0,         1, 2, 1'b0, 1'b0, 4'hF, 5};
      vt[4] = '{1'b1, 1'b0, 4'hC, 32'h8,   32'h0,         0, 3, 1'b0, 1'b0, 4'hC, 5};
      vt[5] = '{1'b1, 1'b1, 4'h8, 32'h20C, 32'hCAFE_F00D, 3, 0, 1'b0, 1'b1, 4'h8, 5};
      vt[6] = '{1'b1, 1'b0, 4'hF, 32'h700, 32'h0,         5, 0, 1'b1, 1'b0, 4'hF, 7};

      exp_order = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h400,
                    32'h1010, 32'h1014, 32'h1018, 32'h101C, 32'h404,
                    32'h1020, 32'h1024};

      mp.i_if_req     = 1'b0;
      mp.i_if_addr    = '0;
      mp.i_if_flush   = 1'b0;
      mp.i_lsu_req    = 1'b0;
      mp.i_lsu_we     = 1'b0;
      mp.i_lsu_be     = '0;
      mp.i_lsu_addr   = '0;
      mp.i_lsu_wdata  = '0;
      mp.i_bus_gnt    = 1'b0;
      mp.i_bus_rvalid = 1'b0;
      mp.i_bus_rdata  = '0;

      // Reset state, with both requesters asserting to see the stalls held low.
      #1 i_rst = 1'b1;
      mp.i_if_req  = 1'b1;
      mp.i_lsu_req = 1'b1;
      #2;
      chk("rst_bus_req",    mp.o_bus_req,    0);
      chk("rst_bus_we",     mp.o_bus_we,     0);
      chk("rst_bus_be",     mp.o_bus_be,     0);
      chk("rst_bus_addr",   mp.o_bus_addr,   0);
      chk("rst_bus_wdata",  mp.o_bus_wdata,  0);
      chk("rst_if_rvalid",  mp.o_if_rvalid,  0);
      chk("rst_lsu_rvalid", mp.o_lsu_rvalid, 0);
      chk("rst_stall_if",   mp.o_stall_if,   0);
      chk("rst_stall_mem",  mp.o_stall_mem,  0);
      mp.i_if_req  = 1'b0;
      mp.i_lsu_req = 1'b0;
      tick(2);
      i_rst = 1'b0;
      tick(1);

      // Single transactions from the vector table.
      for (int i = 0; i < 7; i++) begin
         gnt_delay = vt[i].gd;
         rsp_delay = vt[i].rd;
         bus_log.delete();
         if (vt[i].is_lsu) lsu_op(vt[i].we, vt[i].be, vt[i].addr, vt[i].wdata, vt[i].wig, s1);
         else              if_fetch(vt[i].addr, s1);
         chk($sformatf("v%0d_stall_cycles", i), s1, vt[i].exp_stall);
         chk($sformatf("v%0d_bus_txns", i), bus_log.size(), 1);
         if (bus_log.size() > 0) begin
            chk($sformatf("v%0d_bus_addr", i), bus_log[0].addr, vt[i].addr);
            chk($sformatf("v%0d_bus_we", i),   bus_log[0].we,   vt[i].exp_we);
            chk($sformatf("v%0d_bus_be", i),   bus_log[0].be,   vt[i].exp_be);
            if (vt[i].exp_we) chk($sformatf("v%0d_bus_wdata", i), bus_log[0].wdata, vt[i].wdata);
         end
      end

      // Simultaneous IF fetch and LSU store: LSU first, IF after one IDLE cycle.
      gnt_delay = 0;
      rsp_delay = 0;
      bus_log.delete();
      fork
         if_fetch(32'h300, s1);
         lsu_op(1'b1, 4'h3, 32'h200, 32'hA5A5_0F0F, 1'b0, s2);
      join
      chk("sim_lsu_stall", s2, 2);
      chk("sim_if_stall",  s1, 5);
      chk("sim_bus_txns",  bus_log.size(), 2);
      if (bus_log.size() == 2) begin
         chk("sim_first_addr", bus_log[0].addr, 32'h200);
         chk("sim_first_we",   bus_log[0].we,   1);
         chk("sim_first_be",   bus_log[0].be,   4'h3);
         chk("sim_second_addr", bus_log[1].addr, 32'h300);
         chk("sim_issue_gap",  bus_log[1].cyc - bus_log[0].cyc, 3);
      end

      // LSU streak limit: four LSU grants, then IF, then the streak restarts.
      bus_log.delete();
      fork
         begin
            if_fetch(32'h400, s1);
            if_fetch(32'h404, s1);
         end
         for (int k = 0; k < 10; k++) lsu_op(1'b0, 4'hF, 32'h1000 + 32'(4 * k), 32'h0, 1'b0, s2);
      join
      chk("streak_bus_txns", bus_log.size(), 12);
      for (int k = 0; k < 12; k++) begin
         if (k < bus_log.size()) chk($sformatf("streak_order_%0d", k), bus_log[k].addr, exp_order[k]);
      end

      // Flush in IDLE: no fetch issues that cycle.
      bus_log.delete();
      mp.i_if_req   = 1'b1;
      mp.i_if_addr  = 32'h900;
      mp.i_if_flush = 1'b1;
      tick(1);
      mp.i_if_flush = 1'b0;
      chk("idle_flush_no_req", mp.o_bus_req, 0);
      if_fetch(32'h900, s1);
      chk("idle_flush_then_stall", s1, 2);

      // Flush while the fetch waits on a slow response: data is discarded.
      rsp_delay = 3;
      bus_log.delete();
      mp.i_if_req  = 1'b1;
      mp.i_if_addr = 32'h500;
      tick(2);
      mp.i_if_flush = 1'b1;
      @(negedge i_clk);
      chk("flush_stall_if", mp.o_stall_if, 1);
      chk("flush_no_rvalid", mp.o_if_rvalid, 0);
      tick(1);
      mp.i_if_flush = 1'b0;
      if_fetch(32'h600, s1);
      chk("flush_refetch_stall", s1, 8);
      chk("flush_bus_txns", bus_log.size(), 2);
      if (bus_log.size() == 2) begin
         chk("flush_killed_addr", bus_log[0].addr, 32'h500);
         chk("flush_new_addr",    bus_log[1].addr, 32'h600);
         chk("flush_issue_gap",   bus_log[1].cyc - bus_log[0].cyc, 6);
      end

      // Reset in the middle of an LSU response wait.
      rsp_delay = 5;
      mp.i_lsu_req   = 1'b1;
      mp.i_lsu_we    = 1'b0;
      mp.i_lsu_be    = 4'hF;
      mp.i_lsu_addr  = 32'h800;
      mp.i_lsu_wdata = 32'h0;
      tick(2);
      #2 i_rst = 1'b1;
      #1;
      chk("midrst_bus_req",    mp.o_bus_req,    0);
      chk("midrst_lsu_rvalid", mp.o_lsu_rvalid, 0);
      chk("midrst_if_rvalid",  mp.o_if_rvalid,  0);
      chk("midrst_stall_mem",  mp.o_stall_mem,  0);
      chk("midrst_stall_if",   mp.o_stall_if,   0);
      chk("midrst_bus_addr",   mp.o_bus_addr,   0);
      mp.i_lsu_req = 1'b0;
      tick(2);
      i_rst = 1'b0;
      rsp_delay = 0;
      tick(1);
      if_fetch(32'h904, s1);
      chk("postrst_fetch_stall", s1, 2);

      tick(3);
      chk("if_scoreboard_empty",  if_exp.size(),  0);
      chk("lsu_scoreboard_empty", lsu_exp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory bus between instruction fetch (IF) and the load/store unit (MEM stage). This removes the structural hazard on the bus. The block generates the stall signals that the pipeline control ORs with the load-use hazard stalls.
- One outstanding bus transaction at a time.
- LSU has priority, with a starvation guard for IF.
- Fetches killed by a branch flush are drained and their responses discarded.

Parameters:
- XLEN, 32, address/data width
- MAX_LSU_STREAK, 4, consecutive LSU grants allowed while IF is waiting; after that IF wins one arbitration

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_if_req  in  1  IF fetch request; held until o_if_rvalid or flush
- i_if_addr  in  XLEN  fetch address, word aligned
- i_if_flush  in  1  branch taken: the current fetch is dead
- o_if_rvalid  out  1  fetch data valid this cycle
- o_if_rdata  out  XLEN  fetch data
- o_stall_if  out  1  IF must hold its PC and its request
- i_lsu_req, i_lsu_we  in  1,1  LSU request and write enable; held until o_lsu_rvalid
- i_lsu_be  in  XLEN/8  byte enables
- i_lsu_addr, i_lsu_wdata  in  XLEN,XLEN  LSU address and write data
- o_lsu_rvalid  out  1  LSU access complete (loads and stores)
- o_lsu_rdata  out  XLEN  load data
- o_stall_mem  out  1  stall the MEM stage and everything upstream of it
- o_bus_req, o_bus_we  out  1,1  bus request and write enable
- o_bus_be  out  XLEN/8  bus byte enables
- o_bus_addr, o_bus_wdata  out  XLEN,XLEN  bus address and write data
- i_bus_gnt  in  1  bus accepts the request this cycle
- i_bus_rvalid  in  1  bus response valid, at the earliest 1 cycle after gnt
- i_bus_rdata  in  XLEN  bus response data

Behaviour:
- States: IDLE, REQ_IF, REQ_LSU, RSP_IF, RSP_LSU. Reset value is IDLE.
- Reset values: all outputs 0, streak counter 0, kill flag 0.
- IDLE arbitration, one cycle:
  - LSU request only -> REQ_LSU.
  - IF request only (and no flush this cycle) -> REQ_IF.
  - Both requesting -> REQ_LSU, unless streak == MAX_LSU_STREAK, in which case REQ_IF.
- Entering REQ_x registers addr, we, be and wdata; the requester's inputs are not used again. IF requests set we=0 and be all ones.
- REQ_x: o_bus_req=1 with fields held stable until i_bus_gnt, then -> RSP_x. The request is never withdrawn, even on flush.
- RSP_x: wait for i_bus_rvalid, then -> IDLE.
  - IDLE is mandatory between transactions, so a request still held in the completion cycle cannot issue twice.
  - Minimum request-to-data latency is 2 cycles (IDLE arbitration cycle, then REQ with gnt the same cycle, then rvalid).
- Response pass-through is combinational: o_x_rvalid = i_bus_rvalid in RSP_x; o_x_rdata = i_bus_rdata.
- Stalls:
  - o_stall_if = i_if_req & !o_if_rvalid.
  - o_stall_mem = i_lsu_req & !o_lsu_rvalid.
  - Both are combinational and carry no dependency on the flush.
- Flush:
  - i_if_flush in REQ_IF or RSP_IF sets the kill flag.
  - While the kill flag is set, o_if_rvalid is forced to 0.
  - The flag clears when the transaction returns to IDLE.
  - Flush in IDLE suppresses IF arbitration for that cycle only.
  - Flush does not affect LSU transactions.
- Streak counter:
  - +1 on each LSU grant while i_if_req is high, saturating at MAX_LSU_STREAK.
  - Cleared on an IF grant or when i_if_req is low.
- Reset mid-transaction returns to IDLE immediately. The bus is reset by the same i_rst, so no stale response is expected.

Decomposition:
- Add to cotm32_pkg:
  - arb_state_t enum with the five states.
  - arb_src_t enum: ARB_IF, ARB_LSU.
- Streak counter and FSM stay inline; no sub-module.
- Top-level wiring: o_stall_mem OR'd into the pipeline stall logic; o_stall_if OR'd with the hazard unit's IF stall.

Test Plan:
- Single fetch, addr 0x100, gnt in the REQ cycle, rvalid 1 cycle later with 0xDEADBEEF -> o_if_rvalid pulses for 1 cycle with that data; o_stall_if high for 2 cycles.
- Simultaneous IF and LSU store to 0x200, be=4'b0011 -> LSU issues first with we=1, be=0011; IF issues after the LSU rvalid plus one IDLE cycle.
- LSU requesting continuously with IF waiting, MAX_LSU_STREAK=4 -> exactly 4 LSU grants, then 1 IF grant, then the streak restarts from 0.
- Flush during RSP_IF with the bus holding rvalid back for 3 cycles -> o_if_rvalid stays 0; the arbiter returns to IDLE on the rvalid; the next fetch to the new PC is issued normally.
- i_bus_gnt held low for 5 cycles in REQ_LSU while i_lsu_addr changes -> o_bus_addr stays at the latched value the whole time; o_stall_mem stays high.
- i_rst asserted during RSP_LSU -> o_bus_req=0 and all rvalid/stall outputs 0 asynchronously; state is IDLE after release.
